seg7_scan_ctrl: RTL and testbench

//  Parametrised multiplexed hex display driver for N common-anode 7-segment digits, successor to the fixed 8-digit driver.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment "off" level and the
// hex glyph table (active-high, bit order gfedcba).
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h00;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return HEX_SEG[nib];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with blanking; output is active-high.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_OFF : hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit hex display driver with a shadow load buffer that commits
// only at frame boundaries, leading-zero blanking, enable and output polarity.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIGITS     = 8,
   parameter int PRESCALE_W = 17,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [4*DIGITS-1:0] load_data,
   input  logic [DIGITS-1:0]   load_dp,
   input  logic                blank_lz,
   input  logic                enable,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   an,
   output logic                frame_done
);

   localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [6:0]        SEG_LVL_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic              DP_LVL_OFF  = ACTIVE_LOW;
   localparam logic [DIGITS-1:0] AN_LVL_OFF  = ACTIVE_LOW ? '1 : '0;

   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  frame_done_q, frame_done_d;
   logic                  load_ready_q, load_ready_d;
   logic                  pend_full_q, pend_full_d;
   logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
   logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic [4*DIGITS-1:0]   disp_data_q, disp_data_d;
   logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
   logic                  shown_q, shown_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     an_q, an_d;

   logic                  tick, boundary, xfer, commit;
   logic [4*DIGITS-1:0]   shifted;
   logic [3:0]            cur_nib;
   logic                  cur_blank;
   logic [6:0]            dec_seg;
   logic [DIGITS-1:0]     an_raw;

   // Scan timing and the pending/display buffer handoff
   always_comb begin
      presc_d      = presc_q + PRESCALE_W'(1);
      tick         = &presc_q;
      boundary     = tick && (idx_q == LAST_IDX);
      xfer         = load_valid && load_ready_q;
      commit       = boundary && pend_full_q;
      idx_d        = idx_q;
      pend_full_d  = pend_full_q;
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      disp_data_d  = disp_data_q;
      disp_dp_d    = disp_dp_q;
      shown_d      = shown_q;
      frame_done_d = boundary;
      if (tick) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      if (commit) begin
         disp_data_d = pend_data_q;
         disp_dp_d   = pend_dp_q;
         shown_d     = 1'b1;
         pend_full_d = 1'b0;
      end
      // Ready is low whenever pending is full, so a transfer never collides with a commit
      if (xfer) begin
         pend_full_d = 1'b1;
         pend_data_d = load_data;
         pend_dp_d   = load_dp;
      end
      load_ready_d = !pend_full_d;
   end

   // Output stage: decode the currently selected digit
   always_comb begin
      shifted   = disp_data_q >> {idx_q, 2'b00};
      cur_nib   = shifted[3:0];
      cur_blank = blank_lz && (idx_q != '0) && (shifted == '0);
      an_raw    = '0;
      if (enable && shown_q) begin
         an_raw[idx_q] = 1'b1;
      end
      seg_d = ACTIVE_LOW ? ~dec_seg : dec_seg;
      dp_d  = ACTIVE_LOW ? ~disp_dp_q[idx_q] : disp_dp_q[idx_q];
      an_d  = ACTIVE_LOW ? ~an_raw : an_raw;
   end

   seg7_hex_decode u_dec (
      .nib   (cur_nib),
      .blank (cur_blank),
      .seg   (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_q      <= '0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
         load_ready_q <= 1'b0;
         pend_full_q  <= 1'b0;
         disp_data_q  <= '0;
         disp_dp_q    <= '0;
         shown_q      <= 1'b0;
         seg_q        <= SEG_LVL_OFF;
         dp_q         <= DP_LVL_OFF;
         an_q         <= AN_LVL_OFF;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         frame_done_q <= frame_done_d;
         load_ready_q <= load_ready_d;
         pend_full_q  <= pend_full_d;
         disp_data_q  <= disp_data_d;
         disp_dp_q    <= disp_dp_d;
         shown_q      <= shown_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
      end
   end

   // Pending contents are meaningless while pend_full_q is low
   always_ff @(posedge clk) begin
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
   end

   assign load_ready = load_ready_q;
   assign frame_done = frame_done_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (8 digits active-low, 5 digits
// active-high) checked every cycle against a counter-arithmetic model.
module tb_seg7_scan_ctrl;

   localparam int PW = 2;
   localparam int P  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, blank_lz, enable;
   logic        lv0, rdy0, dp0, fd0;
   logic [31:0] ld0;
   logic [7:0]  ldp0, an0;
   logic [6:0]  seg0;
   logic        lv1, rdy1, dp1, fd1;
   logic [19:0] ld1;
   logic [4:0]  ldp1, an1;
   logic [6:0]  seg1;

   seg7_scan_ctrl #(.DIGITS(8), .PRESCALE_W(PW), .ACTIVE_LOW(1'b1)) u0 (
      .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy0), .load_data(ld0),
      .load_dp(ldp0), .blank_lz(blank_lz), .enable(enable), .seg(seg0), .dp(dp0),
      .an(an0), .frame_done(fd0)
   );

   seg7_scan_ctrl #(.DIGITS(5), .PRESCALE_W(PW), .ACTIVE_LOW(1'b0)) u1 (
      .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1), .load_data(ld1),
      .load_dp(ldp1), .blank_lz(blank_lz), .enable(enable), .seg(seg1), .dp(dp1),
      .an(an1), .frame_done(fd1)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: position in the scan is derived from a cycle count
   logic [6:0]  HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int          nd [2] = '{8, 5};
   bit          al [2] = '{1'b1, 1'b0};
   int unsigned cnt [2];
   bit          pfull [2];
   logic [63:0] pdata [2];
   logic [15:0] pdp [2];
   logic [63:0] disp [2];
   logic [15:0] ddp [2];
   bit          shown [2];
   logic [6:0]  e_seg [2];
   logic        e_dp [2];
   logic [15:0] e_an [2];
   logic        e_fd [2];
   logic        e_rdy [2];
   bit          e_segv [2];
   bit          mvalid = 1'b0;

   task automatic mstep(input int k, input logic lv, input logic [63:0] ld, input logic [15:0] ldp);
      int          idx, presc;
      bit          bnd, transfer;
      logic [63:0] sh;
      logic [15:0] mask, a;
      logic [6:0]  s;
      logic        d;
      mask = (16'h1 << nd[k]) - 16'h1;
      if (!rst) begin
         cnt[k] = 0; pfull[k] = 0; disp[k] = '0; ddp[k] = '0; shown[k] = 0;
         e_seg[k] = al[k] ? 7'h7F : 7'h00;
         e_dp[k]  = al[k];
         e_an[k]  = al[k] ? mask : 16'h0;
         e_fd[k]  = 1'b0; e_rdy[k] = 1'b0; e_segv[k] = 1'b0;
      end else begin
         presc = int'(cnt[k] % P);
         idx   = int'((cnt[k] / P) % nd[k]);
         bnd   = (presc == P - 1) && (idx == nd[k] - 1);
         sh    = disp[k] >> (4 * idx);
         s     = (blank_lz && idx > 0 && sh == 64'h0) ? 7'h00 : HEX[sh[3:0]];
         d     = ddp[k][idx];
         a     = (enable && shown[k]) ? (16'h1 << idx) : 16'h0;
         e_segv[k] = shown[k];
         e_seg[k]  = al[k] ? ~s : s;
         e_dp[k]   = al[k] ? ~d : d;
         e_an[k]   = al[k] ? (~a & mask) : a;
         e_fd[k]   = bnd;
         transfer  = lv && e_rdy[k];
         if (bnd && pfull[k]) begin
            disp[k] = pdata[k]; ddp[k] = pdp[k]; shown[k] = 1; pfull[k] = 0;
         end
         if (transfer) begin
            pfull[k] = 1; pdata[k] = ld; pdp[k] = ldp;
         end
         e_rdy[k] = !pfull[k];
         cnt[k]++;
      end
   endtask

   always @(posedge clk) begin
      mstep(0, lv0, 64'(ld0), 16'(ldp0));
      mstep(1, lv1, 64'(ld1), 16'(ldp1));
      mvalid = 1'b1;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("u0_an", an0, e_an[0][7:0]);
         chk("u0_frame_done", fd0, e_fd[0]);
         chk("u0_load_ready", rdy0, e_rdy[0]);
         if (e_segv[0]) begin
            chk("u0_seg", seg0, e_seg[0]);
            chk("u0_dp", dp0, e_dp[0]);
         end
         chk("u1_an", an1, e_an[1][4:0]);
         chk("u1_frame_done", fd1, e_fd[1]);
         chk("u1_load_ready", rdy1, e_rdy[1]);
         if (e_segv[1]) begin
            chk("u1_seg", seg1, e_seg[1]);
            chk("u1_dp", dp1, e_dp[1]);
         end
      end
   end

   task automatic load0(input logic [31:0] d, input logic [7:0] p);
      bit ok, got;
      lv0 = 1'b1; ld0 = d; ldp0 = p; ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         got = rdy0;
         @(negedge clk);
         if (got) ok = 1;
      end
      lv0 = 1'b0;
      chk("load0_accept", ok, 1);
   endtask

   task automatic load1(input logic [19:0] d, input logic [4:0] p);
      bit ok, got;
      lv1 = 1'b1; ld1 = d; ldp1 = p; ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         got = rdy1;
         @(negedge clk);
         if (got) ok = 1;
      end
      lv1 = 1'b0;
      chk("load1_accept", ok, 1);
   endtask

   task automatic wait_fd0();
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (fd0) ok = 1;
      end
      chk("wait_fd0", ok, 1);
   endtask

   task automatic wait_fd1();
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (fd1) ok = 1;
      end
      chk("wait_fd1", ok, 1);
   endtask

   task automatic wait_an0(input logic [7:0] target);
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (an0 == target) ok = 1;
      end
      chk("wait_an0", ok, 1);
   endtask

   task automatic wait_an1(input logic [4:0] target);
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (an1 == target) ok = 1;
      end
      chk("wait_an1", ok, 1);
   endtask

   initial begin
      int n;
      bit seen;
      rst = 1'b0; blank_lz = 1'b0; enable = 1'b1;
      lv0 = 1'b0; ld0 = '0; ldp0 = '0;
      lv1 = 1'b0; ld1 = '0; ldp1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_seg0", seg0, 7'h7F);
      chk("rst_dp0", dp0, 1'b1);
      chk("rst_an0", an0, 8'hFF);
      chk("rst_rdy0", rdy0, 1'b0);
      chk("rst_fd0", fd0, 1'b0);
      chk("rst_seg1", seg1, 7'h00);
      chk("rst_an1", an1, 5'h00);
      rst = 1'b1;
      @(negedge clk);
      chk("rdy0_after_rst", rdy0, 1'b1);

      load0(32'h1234_ABCD, 8'h00);
      chk("rdy0_low_after_load", rdy0, 1'b0);
      wait_fd0();
      wait_an0(8'hFE);
      chk("t2_digit0_seg", seg0, 7'h21);
      wait_an0(8'h7F);
      chk("t2_digit7_seg", seg0, 7'h79);
      wait_fd0();
      n = 0; seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (fd0) seen = 1;
      end
      chk("t2_frame_period", n, 32);

      load0(32'h89AB_CDEF, 8'h0F);
      load0(32'h0000_0042, 8'h00);
      chk("t3_b_pending", rdy0, 1'b0);

      blank_lz = 1'b1;
      load0(32'h0000_00F0, 8'h00);
      wait_fd0();
      wait_an0(8'hDF);
      chk("t4_digit5_blank", seg0, 7'h7F);
      wait_an0(8'hFD);
      chk("t4_digit1_F", seg0, 7'h0E);
      wait_an0(8'hFE);
      chk("t4_digit0_0", seg0, 7'h40);
      load0(32'h0, 8'h00);
      wait_fd0();
      wait_an0(8'hF7);
      chk("t4_zero_digit3_blank", seg0, 7'h7F);
      wait_an0(8'hFE);
      chk("t4_zero_digit0", seg0, 7'h40);

      enable = 1'b0;
      @(negedge clk);
      chk("t5_enable_off", an0, 8'hFF);
      repeat (13) @(negedge clk);
      enable = 1'b1;
      repeat (10) @(negedge clk);
      blank_lz = 1'b0;

      load1(20'h12345, 5'b00100);
      wait_fd1();
      wait_an1(5'b00100);
      chk("u1_dp_digit2", dp1, 1'b1);
      wait_an1(5'b00001);
      chk("u1_dp_digit0", dp1, 1'b0);
      chk("u1_seg_digit0", seg1, 7'h6D);

      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         lv0 = ($urandom_range(0, 3) == 0);
         ld0 = $urandom;
         ldp0 = 8'($urandom);
         lv1 = ($urandom_range(0, 3) == 0);
         ld1 = 20'($urandom);
         ldp1 = 5'($urandom);
         if (i % 50 == 0) blank_lz = 1'($urandom);
         if (i % 70 == 0) enable = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      lv0 = 1'b0; lv1 = 1'b0; enable = 1'b1; blank_lz = 1'b0;

      wait_fd0();
      wait_fd0();
      load0(32'h5555_5555, 8'hFF);
      chk("t6_pending_full", rdy0, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_rst_an", an0, 8'hFF);
      chk("t6_rst_seg", seg0, 7'h7F);
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (an0 != 8'hFF) n++;
      end
      chk("t6_nothing_lit", n, 0);
      load0(32'h0000_0007, 8'h01);
      wait_fd0();
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
